instr_cache_ctrl: RTL and testbench
===================================

# instr_cache_ctrl

Miss-handling sequencer for the direct-mapped instruction cache core. Accepts fetch requests from the pipeline, uses the core's hit signal to answer hits in the same cycle, and on a miss fetches the block from memory as a burst of word beats. It assembles the beats into a full block and writes it into the core with a single bwrite pulse. Sits between the fetch stage, the cache core and the memory/bus interface.

## Interface
- dsize, 32, word width (bits)
- asize, 32, address width
- bbits, 5, block offset bits (32-byte block)
- bsize, 8<<bbits, block width (256)
- nbeats, bsize/dsize, words per block fill (8)

- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-low reset
- SYS  in  1  flush request; same signal the core uses to clear valid bits
- cpu_req  in  1  fetch request this cycle
- cpu_addr  in  asize  fetch address
- cpu_ready  out  1  fetch completes this cycle; data taken from the core's data_out1
- cpu_stall  out  1  controller busy with a miss; fetch stage must hold
- core_hit  in  1  core hit1 for core_addr
- core_addr  out  asize  address driven to the core's address1
- core_bread  out  1  read strobe to the core
- core_bwrite  out  1  block write strobe, one-cycle pulse
- core_block  out  bsize  fill block to the core's block_in
- mem_req  out  1  burst request, held for the whole burst
- mem_addr  out  asize  block-aligned burst address (low bbits zero)
- mem_valid  in  1  beat present on mem_data
- mem_data  in  dsize  beat data
- miss_cnt  out  16  miss counter; wraps at 16 bits

## Operation
- Reset values:
  - State IDLE.
  - cpu_ready, cpu_stall, core_bwrite, mem_req all 0.
  - mem_addr, core_block, beat counter, miss_cnt all 0.
- States: IDLE, FILL, WRITE, RETRY.
- **IDLE**
  - core_addr = cpu_addr; core_bread = cpu_req.
  - cpu_req & core_hit: cpu_ready=1, stay in IDLE.
  - cpu_req & !core_hit & !SYS:
    - latch miss_addr = cpu_addr with offset cleared;
    - miss_cnt += 1; beat counter = 0;
    - next state FILL.
  - cpu_req with SYS high: no hit, no miss; the core is flushing.
- **FILL**
  - mem_req=1, mem_addr=miss_addr, cpu_stall=1, core_addr=miss_addr.
  - Each cycle with mem_valid: beat k lands in core_block[bsize-1-k*dsize : bsize-(k+1)*dsize], so beat 0 is the most significant word (offset 0). Counter increments.
  - On beat nbeats-1: mem_req drops the next cycle and the state moves to WRITE.
  - mem_valid low: hold state and counter, insert wait states.
- **WRITE**
  - core_bwrite=1 for exactly one cycle, with core_addr=miss_addr and core_block stable.
  - Suppressed when abort flag is set (see boundaries).
  - cpu_stall=1; next state RETRY.
- **RETRY**
  - core_addr = cpu_addr; cpu_stall=0.
  - Behaves as IDLE for that cycle, so the refetch hits on the same cycle; then IDLE.
- mem_valid outside FILL is ignored.

## Timing
- Hit: cpu_ready combinational in the request cycle; zero added latency.
- Miss with b wait-free beats:
  - request cycle N;
  - FILL cycles N+1..N+8;
  - WRITE at N+9;
  - RETRY and hit at N+10.
  - Each wait cycle adds one.
- cpu_stall is registered: high from N+1 through WRITE inclusive.
- Boundaries:
  - cpu_addr changing or cpu_req dropping mid-miss: ignored. The fill completes and is written, using the latched miss_addr.
  - SYS during FILL:
    - the burst still completes (no mid-burst abort on the bus);
    - an abort flag is set, core_bwrite is suppressed in WRITE, and the core stays flushed.
  - SYS during WRITE: bwrite is suppressed (the core's SYS has priority).
  - RESET low in any state: IDLE next edge, mem_req 0, counter 0, abort flag clear, miss_cnt 0. An outstanding memory burst is the bus's responsibility.
  - miss_cnt at 0xFFFF followed by a miss: wraps to 0x0000.
  - Beat counter wraps only through the WRITE transition; it never exceeds nbeats-1.

## Test plan
- Reset, then cpu_req=1, addr 0x00400000, core_hit=1 -> cpu_ready=1 same cycle, mem_req stays 0, miss_cnt 0.
- Miss at 0x00400024, 8 back-to-back beats 0x11111111..0x88888888 ->
  - mem_addr=0x00400020;
  - core_block = 0x1111…8888 with 0x11111111 in bits [255:224];
  - core_bwrite pulses once at N+9;
  - cpu_ready at N+10; miss_cnt=1.
- Same miss with mem_valid low every other cycle -> WRITE at N+17, block contents identical, mem_req high continuously until the last beat.
- SYS pulsed at the 3rd beat of a fill -> all 8 beats consumed, core_bwrite never asserted, controller back in IDLE.
- RESET low at the 5th beat -> next cycle mem_req=0, cpu_stall=0, miss_cnt=0. A following miss restarts cleanly at beat 0.
- Preload miss_cnt by forcing 65535 misses (or a backdoor) -> the next miss reads 0x0000.

Source files
------------

// File: rtl/instr_cache_ctrl.sv
// instr_cache_ctrl
// Miss-handling sequencer for the direct-mapped instruction cache core.
// Hits are answered combinationally from the core's hit signal. A miss
// fetches the whole block from memory as a burst of word beats, packs the
// beats MSW-first into a block register and writes the block into the core
// with a single bwrite pulse, then replays the fetch so it hits.
module instr_cache_ctrl #(
    parameter int dsize  = 32,
    parameter int asize  = 32,
    parameter int bbits  = 5,
    parameter int bsize  = 8 << bbits,
    parameter int nbeats = bsize / dsize
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYS,
    input  logic             cpu_req,
    input  logic [asize-1:0] cpu_addr,
    output logic             cpu_ready,
    output logic             cpu_stall,
    input  logic             core_hit,
    output logic [asize-1:0] core_addr,
    output logic             core_bread,
    output logic             core_bwrite,
    output logic [bsize-1:0] core_block,
    output logic             mem_req,
    output logic [asize-1:0] mem_addr,
    input  logic             mem_valid,
    input  logic [dsize-1:0] mem_data,
    output logic [15:0]      miss_cnt
);

    localparam int cnt_w = (nbeats > 1) ? $clog2(nbeats) : 1;
    localparam logic [cnt_w-1:0] last_beat_c = cnt_w'(nbeats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RETRY = 2'd3
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [asize-1:0]               miss_addr_r;
    logic [asize-1:0]               line_addr_s;
    logic [nbeats-1:0][dsize-1:0]   words_r;
    logic [cnt_w-1:0]               beat_cnt_r;
    logic [cnt_w-1:0]               word_idx_s;
    logic                           abort_r;
    logic [15:0]                    miss_cnt_r;
    logic                           cpu_stall_r;
    logic                           mem_req_r;
    logic                           start_miss_s;
    logic                           beat_take_s;
    logic                           abort_set_s;

    // Block-aligned form of the fetch address; low offset bits forced to zero.
    assign line_addr_s = {cpu_addr[asize-1:bbits], {bbits{1'b0}}};

    // Beat k is stored in the word slot counted down from the MSW, so beat 0
    // (offset 0) ends up in the most significant bits of the block.
    assign word_idx_s = last_beat_c - beat_cnt_r;

    assign cpu_stall  = cpu_stall_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = miss_addr_r;
    assign core_block = words_r;
    assign miss_cnt   = miss_cnt_r;

    // Next-state and combinational outputs; IDLE and RETRY share hit/miss logic.
    always_comb begin
        state_nxt_s  = state_r;
        cpu_ready    = 1'b0;
        core_bread   = 1'b0;
        core_bwrite  = 1'b0;
        core_addr    = cpu_addr;
        start_miss_s = 1'b0;
        beat_take_s  = 1'b0;
        abort_set_s  = 1'b0;
        case (state_r)
            IDLE, RETRY: begin
                core_bread = cpu_req;
                if (cpu_req && !SYS) begin
                    if (core_hit) begin
                        cpu_ready   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        start_miss_s = 1'b1;
                        state_nxt_s  = FILL;
                    end
                end else begin
                    // No request, or the core is flushing: neither hit nor miss.
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                core_addr   = miss_addr_r;
                // A flush mid-burst cannot stop the bus; remember it instead.
                abort_set_s = SYS;
                if (mem_valid) begin
                    beat_take_s = 1'b1;
                    if (beat_cnt_r == last_beat_c) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            WRITE: begin
                core_addr = miss_addr_r;
                // A flush seen during the fill or right now wins over the write.
                if (!abort_r && !SYS) begin
                    core_bwrite = 1'b1;
                end else begin
                    core_bwrite = 1'b0;
                end
                state_nxt_s = RETRY;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered stall and burst request, derived from the state being entered.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cpu_stall_r <= 1'b0;
            mem_req_r   <= 1'b0;
        end else begin
            cpu_stall_r <= (state_nxt_s == FILL) || (state_nxt_s == WRITE);
            mem_req_r   <= (state_nxt_s == FILL);
        end
    end

    // Latch the block-aligned miss address when a miss starts.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            miss_addr_r <= {asize{1'b0}};
        end else if (start_miss_s) begin
            miss_addr_r <= line_addr_s;
        end
    end

    // Beat counter: cleared on miss start, advances per accepted beat and
    // wraps back to zero only on the last beat that leads into WRITE.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            beat_cnt_r <= {cnt_w{1'b0}};
        end else if (start_miss_s) begin
            beat_cnt_r <= {cnt_w{1'b0}};
        end else if (beat_take_s) begin
            beat_cnt_r <= beat_cnt_r + cnt_w'(1);
        end
    end

    // Block assembly register: each accepted beat lands in its word slot.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            words_r <= {bsize{1'b0}};
        end else if (beat_take_s) begin
            words_r[word_idx_s] <= mem_data;
        end
    end

    // Abort flag: set by a flush during the fill, cleared by the next miss.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            abort_r <= 1'b0;
        end else if (start_miss_s) begin
            abort_r <= 1'b0;
        end else if (abort_set_s) begin
            abort_r <= 1'b1;
        end
    end

    // Miss counter, free-running modulo 2^16.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            miss_cnt_r <= 16'd0;
        end else if (start_miss_s) begin
            miss_cnt_r <= miss_cnt_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Self-checking bench for instr_cache_ctrl: table-driven idle vectors,
// hand-written miss sequences for the timing/abort/reset/wrap corners, and
// randomized hits and misses checked against a transaction-level model.
module tb_instr_cache_ctrl;

    logic         CLK;
    logic         RESET;
    logic         SYS;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         cpu_ready;
    logic         cpu_stall;
    logic         core_hit;
    logic [31:0]  core_addr;
    logic         core_bread;
    logic         core_bwrite;
    logic [255:0] core_block;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [31:0]  mem_data;
    logic [15:0]  miss_cnt;

    int           checks;
    int           failures;
    logic [15:0]  exp_cnt;

    instr_cache_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SYS         (SYS),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .cpu_stall   (cpu_stall),
        .core_hit    (core_hit),
        .core_addr   (core_addr),
        .core_bread  (core_bread),
        .core_bwrite (core_bwrite),
        .core_block  (core_block),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .miss_cnt    (miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%064h exp=%064h t=%0t", name, act, exp, $time);
        end
    endtask

    // One hit in IDLE followed by a quiet cycle.
    task automatic hit_cycle(input logic [31:0] a);
        @(negedge CLK);
        cpu_req   = 1'b1;
        core_hit  = 1'b1;
        SYS       = 1'b0;
        cpu_addr  = a;
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = $urandom;
        #1;
        chk1("hit_ready", cpu_ready, 1'b1);
        chk1("hit_bread", core_bread, 1'b1);
        chk32("hit_core_addr", core_addr, a);
        chk1("hit_mem_req", mem_req, 1'b0);
        @(negedge CLK);
        cpu_req   = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk1("hit_after_stall", cpu_stall, 1'b0);
        chk1("hit_after_mem_req", mem_req, 1'b0);
        chk32("hit_after_cnt", 32'(miss_cnt), 32'(exp_cnt));
    endtask

    // One complete miss. mode 0: beats back-to-back, 1: valid on even cycles
    // only, 2: random gaps. sys_beat / rst_beat name the beat index during
    // which SYS / RESET is pulsed (-1 for none); sys_write flushes in WRITE.
    task automatic run_miss(input logic [31:0] addr, input int mode, input bit fixed,
                            input int sys_beat, input bit sys_write, input int rst_beat);
        logic [255:0] exp_blk;
        logic [31:0]  base;
        int           sent;
        int           c_last;
        bit           abort;
        bit           done;
        bit           valid;
        bit           rst_now;
        exp_blk = '0;
        base    = {addr[31:5], 5'b00000};
        sent    = 0;
        c_last  = -1;
        abort   = 1'b0;
        done    = 1'b0;
        // Request cycle N.
        @(negedge CLK);
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        core_hit  = 1'b0;
        SYS       = 1'b0;
        mem_valid = 1'b0;
        mem_data  = $urandom;
        #1;
        chk1("miss_req_ready", cpu_ready, 1'b0);
        chk1("miss_req_bread", core_bread, 1'b1);
        chk1("miss_req_mem_req", mem_req, 1'b0);
        exp_cnt = exp_cnt + 16'd1;
        for (int c = 1; c <= 200; c++) begin
            if (!done) begin
                @(negedge CLK);
                // Fetch-stage noise during the miss must be ignored.
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                core_hit  = 1'($urandom_range(0, 1));
                SYS       = 1'b0;
                mem_valid = 1'b0;
                mem_data  = $urandom;
                rst_now   = 1'b0;
                if (sent < 8) begin
                    if (mode == 0) begin
                        valid = 1'b1;
                    end else if (mode == 1) begin
                        valid = (c % 2 == 0);
                    end else begin
                        valid = ($urandom_range(0, 2) != 0);
                    end
                    if (valid) begin
                        mem_valid = 1'b1;
                        if (fixed) begin
                            mem_data = 32'h11111111 * 32'(sent + 1);
                        end
                        exp_blk[255 - 32*sent -: 32] = mem_data;
                        if (sent == sys_beat) begin
                            SYS   = 1'b1;
                            abort = 1'b1;
                        end
                        if (sent == rst_beat) begin
                            RESET   = 1'b0;
                            rst_now = 1'b1;
                        end
                        sent++;
                        if (sent == 8) begin
                            c_last = c;
                        end
                    end
                    #1;
                    chk1("fill_stall", cpu_stall, 1'b1);
                    chk1("fill_mem_req", mem_req, 1'b1);
                    chk32("fill_mem_addr", mem_addr, base);
                    chk32("fill_core_addr", core_addr, base);
                    chk1("fill_ready", cpu_ready, 1'b0);
                    chk1("fill_bwrite", core_bwrite, 1'b0);
                    if (rst_now) begin
                        @(negedge CLK);
                        RESET     = 1'b1;
                        cpu_req   = 1'b0;
                        mem_valid = 1'b0;
                        SYS       = 1'b0;
                        #1;
                        exp_cnt = 16'd0;
                        chk1("rst_mem_req", mem_req, 1'b0);
                        chk1("rst_stall", cpu_stall, 1'b0);
                        chk32("rst_miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
                        chk1("rst_bwrite", core_bwrite, 1'b0);
                        done = 1'b1;
                    end
                end else if (c == c_last + 1) begin
                    // WRITE cycle.
                    if (sys_write) begin
                        SYS   = 1'b1;
                        abort = 1'b1;
                    end
                    #1;
                    chk1("write_bwrite", core_bwrite, !abort);
                    chk256("write_block", core_block, exp_blk);
                    chk32("write_core_addr", core_addr, base);
                    chk1("write_stall", cpu_stall, 1'b1);
                    chk1("write_mem_req", mem_req, 1'b0);
                    chk1("write_ready", cpu_ready, 1'b0);
                    if (mode < 2) begin
                        chk32("write_cycle", 32'(c), (mode == 0) ? 32'd9 : 32'd17);
                    end
                end else begin
                    // RETRY cycle: refetch hits unless the fill was aborted.
                    cpu_req  = !abort;
                    cpu_addr = addr;
                    core_hit = 1'b1;
                    #1;
                    chk1("retry_ready", cpu_ready, !abort);
                    chk1("retry_bread", core_bread, !abort);
                    chk32("retry_core_addr", core_addr, addr);
                    chk1("retry_stall", cpu_stall, 1'b0);
                    chk1("retry_mem_req", mem_req, 1'b0);
                    chk1("retry_bwrite", core_bwrite, 1'b0);
                    chk32("retry_miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL miss_timeout got=no_retry exp=retry_within_200 t=%0t", $time);
        end
    endtask

    typedef struct {
        logic        req;
        logic        hit;
        logic        sys;
        logic [31:0] addr;
        logic        exp_ready;
        logic        exp_bread;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt   = 16'd0;
        RESET     = 1'b0;
        SYS       = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        core_hit  = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 32'h0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00400000, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h00400004, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEC, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b1};

        // Reset values.
        repeat (2) @(negedge CLK);
        #1;
        chk1("reset_stall", cpu_stall, 1'b0);
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_bwrite", core_bwrite, 1'b0);
        chk32("reset_mem_addr", mem_addr, 32'h0);
        chk256("reset_block", core_block, 256'h0);
        chk32("reset_miss_cnt", 32'(miss_cnt), 32'h0);
        RESET = 1'b1;

        // Idle-state vectors: hits, idle, and requests during a flush.
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            cpu_req  = vecs[i].req;
            core_hit = vecs[i].hit;
            SYS      = vecs[i].sys;
            cpu_addr = vecs[i].addr;
            #1;
            chk1("vec_ready", cpu_ready, vecs[i].exp_ready);
            chk1("vec_bread", core_bread, vecs[i].exp_bread);
            chk32("vec_core_addr", core_addr, vecs[i].addr);
            chk1("vec_stall", cpu_stall, 1'b0);
            chk1("vec_mem_req", mem_req, 1'b0);
            chk32("vec_miss_cnt", 32'(miss_cnt), 32'h0);
        end
        @(negedge CLK);
        cpu_req = 1'b0;
        SYS     = 1'b0;
        #1;
        chk1("vec_end_stall", cpu_stall, 1'b0);
        chk1("vec_end_mem_req", mem_req, 1'b0);

        // Back-to-back fill, then the same miss with alternate wait states.
        run_miss(32'h00400024, 0, 1'b1, -1, 1'b0, -1);
        chk32("miss1_cnt", 32'(miss_cnt), 32'd1);
        run_miss(32'h00400024, 1, 1'b1, -1, 1'b0, -1);

        // Flush at the 3rd beat, then flush during WRITE.
        run_miss(32'h00800040, 0, 1'b0, 2, 1'b0, -1);
        hit_cycle(32'h00800040);
        run_miss(32'h00A00010, 2, 1'b0, -1, 1'b1, -1);
        hit_cycle(32'h00A00010);

        // Reset at the 5th beat, then a clean miss from beat 0.
        run_miss(32'h01000000, 0, 1'b0, -1, 1'b0, 4);
        run_miss(32'h01000008, 0, 1'b1, -1, 1'b0, -1);
        chk32("post_rst_cnt", 32'(miss_cnt), 32'd1);

        // Miss counter wrap via backdoor preload.
        @(negedge CLK);
        cpu_req = 1'b0;
        force dut.miss_cnt_r = 16'hFFFF;
        @(negedge CLK);
        release dut.miss_cnt_r;
        #1;
        chk32("preload_cnt", 32'(miss_cnt), 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        run_miss(32'h02000000, 0, 1'b0, -1, 1'b0, -1);
        chk32("wrap_cnt", 32'(miss_cnt), 32'h00000000);

        // Randomized hits and misses.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hit_cycle($urandom);
            end else begin
                run_miss($urandom, 2, 1'b0,
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                         ($urandom_range(0, 5) == 0), -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
